// File: rtl/cart_loader.sv
// Cartridge ROM loader: streams an HPS download into a single-port ROM BRAM,
// then serves cartridge-mapper reads from the same BRAM while the core runs.
module cart_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [23:0] ioctl_ext,
  input  logic [1:0]  sc_mode,
  input  logic        cpu_req,
  input  logic [14:0] cpu_addr,
  output logic        cpu_ack,
  output logic [7:0]  cpu_data,
  output logic [14:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_din,
  input  logic [7:0]  mem_dout,
  output logic        core_reset,
  output logic [3:0]  force_bs,
  output logic        sc,
  output logic [16:0] rom_size,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN} state_t;

  localparam logic [16:0] ROM_SIZE_MAX = 17'h1FFFF;

  state_t      state_q, state_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic [16:0] rom_size_q, rom_size_d;
  logic [3:0]  force_bs_q, force_bs_d;
  logic        sc_q, sc_d;
  logic        ack_q, ack_d;
  logic [7:0]  data_q, data_d;

  function automatic logic [3:0] decode_bs(input logic [23:0] ext);
    case (ext)
      ".F8":   decode_bs = 4'd1;
      ".F6":   decode_bs = 4'd2;
      ".FE":   decode_bs = 4'd3;
      ".E0":   decode_bs = 4'd4;
      ".3F":   decode_bs = 4'd5;
      ".F4":   decode_bs = 4'd6;
      ".P2":   decode_bs = 4'd7;
      ".FA":   decode_bs = 4'd8;
      ".CV":   decode_bs = 4'd9;
      ".UA":   decode_bs = 4'd11;
      default: decode_bs = 4'd0;
    endcase
  endfunction

  function automatic logic decode_sc(input logic [7:0] last_char, input logic [1:0] mode);
    case (mode)
      2'd0:    decode_sc = (last_char == "S");
      2'd1:    decode_sc = 1'b0;
      default: decode_sc = 1'b1;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = 4'd0;
    rom_size_d = rom_size_q;
    force_bs_d = force_bs_q;
    sc_d       = sc_q;
    ack_d      = 1'b0;
    data_d     = ack_q ? mem_dout : data_q;
    mem_we     = 1'b0;
    mem_addr   = cpu_addr;
    mem_din    = ioctl_dout;

    case (state_q)
      S_IDLE: state_d = ioctl_download ? S_LOAD : S_HOLD;
      S_LOAD: begin
        if (ioctl_wr) begin
          if (rom_size_q != ROM_SIZE_MAX) rom_size_d = rom_size_q + 17'd1;
          // Bytes past 32 KiB are counted but have no BRAM location.
          if (ioctl_addr[24:15] == 10'd0) begin
            mem_we   = 1'b1;
            mem_addr = ioctl_addr[14:0];
          end
        end
        if (!ioctl_download) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (ioctl_download) begin
          state_d = S_LOAD;
        end else begin
          hold_cnt_d = hold_cnt_q + 4'd1;
          if (hold_cnt_q == 4'hF) state_d = S_RUN;
        end
      end
      S_RUN: begin
        // A request on the final RUN cycle is still acknowledged after leaving RUN.
        ack_d = cpu_req;
        if (ioctl_download) state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_LOAD && state_q != S_LOAD) begin
      rom_size_d = 17'd0;
      force_bs_d = decode_bs(ioctl_ext);
      sc_d       = decode_sc(ioctl_ext[7:0], sc_mode);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      hold_cnt_q <= 4'd0;
      rom_size_q <= 17'd0;
      force_bs_q <= 4'd0;
      sc_q       <= 1'b0;
      ack_q      <= 1'b0;
      data_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rom_size_q <= rom_size_d;
      force_bs_q <= force_bs_d;
      sc_q       <= sc_d;
      ack_q      <= ack_d;
      data_q     <= data_d;
    end
  end

  // Read data comes straight from the BRAM on the ack cycle, then is held.
  assign cpu_ack    = ack_q;
  assign cpu_data   = ack_q ? mem_dout : data_q;
  assign core_reset = (state_q != S_RUN);
  assign busy       = (state_q != S_RUN);
  assign force_bs   = force_bs_q;
  assign sc         = sc_q;
  assign rom_size   = rom_size_q;

endmodule

// File: doc/cart_loader.md
CART_LOADER -- requirements
Module: cart_loader

Interface
REQ-001 clk  in  1  system clock; all logic on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 ioctl_download  in  1  HPS download active (level).
REQ-004 ioctl_wr  in  1  one-cycle write strobe for ioctl_dout.
REQ-005 ioctl_addr  in  25  byte address of current download byte.
REQ-006 ioctl_dout  in  8  download data byte.
REQ-007 ioctl_ext  in  24  file extension as ASCII ".XY"; bits[7:0] hold the last character.
REQ-008 sc_mode  in  2  SuperChip option: 0 auto, 1 disable, 2/3 enable.
REQ-009 cpu_req  in  1  single-cycle ROM read request from the cartridge mapper.
REQ-010 cpu_addr  in  15  ROM read address.
REQ-011 cpu_ack  out  1  read data valid, one-cycle pulse.
REQ-012 cpu_data  out  8  read data, held until the next cpu_ack.
REQ-013 mem_addr  out  15  single-port ROM BRAM address.
REQ-014 mem_we  out  1  BRAM write enable.
REQ-015 mem_din  out  8  BRAM write data.
REQ-016 mem_dout  in  8  BRAM read data; one-cycle read latency.
REQ-017 core_reset  out  1  hold-reset to the console core.
REQ-018 force_bs  out  4  bank-switch scheme code.
REQ-019 sc  out  1  SuperChip RAM enable.
REQ-020 rom_size  out  17  accepted byte count of the last download.
REQ-021 busy  out  1  high in every state except RUN.

Function
REQ-022 FSM states: IDLE, LOAD, HOLD, RUN.
REQ-023 IDLE transitions after one cycle: to LOAD if ioctl_download=1, else to HOLD.
REQ-024 RUN transitions to LOAD on the cycle ioctl_download is sampled high.
REQ-025 On LOAD entry: rom_size cleared to 0; force_bs and sc latched from ioctl_ext and sc_mode; neither output changes again until the next LOAD entry.
REQ-026 force_bs decode of ioctl_ext: F8=1, F6=2, FE=3, E0=4, 3F=5, F4=6, P2=7, FA=8, CV=9, UA=11, any other value=0.
REQ-027 sc decode: sc_mode 0 gives (ioctl_ext[7:0]=="S"); sc_mode 1 gives 0; sc_mode 2 or 3 gives 1.
REQ-028 LOAD, ioctl_wr=1 with ioctl_addr[24:15]=0: mem_we=1, mem_addr=ioctl_addr[14:0], mem_din=ioctl_dout in the same cycle (combinational pass-through).
REQ-029 LOAD, ioctl_wr=1 with ioctl_addr[24:15]!=0: no BRAM write; the byte still counts toward rom_size.
REQ-030 rom_size increments by 1 per ioctl_wr in LOAD and saturates at 0x1FFFF.
REQ-031 LOAD transitions to HOLD on the cycle ioctl_download is sampled low.
REQ-032 HOLD lasts exactly 16 cycles, counted by a 4-bit counter, then transitions to RUN; ioctl_download=1 during HOLD goes to LOAD immediately.
REQ-033 core_reset is 1 in IDLE, LOAD and HOLD, and 0 only in RUN.
REQ-034 RUN, cpu_req=1: mem_addr=cpu_addr and mem_we=0; the next cycle gives cpu_ack=1 and cpu_data=mem_dout (registered).
REQ-035 Back-to-back cpu_req on consecutive cycles is supported with full throughput (one ack per request, in order).
REQ-036 cpu_req outside RUN is dropped: no ack, no BRAM access. A write always wins over a simultaneous cpu_req.
REQ-037 A cpu_req issued on the last RUN cycle before a LOAD transition is still acknowledged on the following cycle.
REQ-038 mem_we is 0 in every state except LOAD.

Reset
REQ-039 Reset puts the FSM in IDLE and clears the HOLD counter.
REQ-040 Reset output values: core_reset=1, busy=1, cpu_ack=0, cpu_data=0, mem_we=0, force_bs=0, sc=0, rom_size=0.
REQ-041 Reset during LOAD aborts the load; if ioctl_download is still high, the load restarts with rom_size=0 after IDLE.

Verification
REQ-042 Reset with download low -> 1 IDLE cycle + 16 HOLD cycles with core_reset=1; core_reset=0 and busy=0 on cycle 18.
REQ-043 Download of 4096 bytes with ext ".F8" and sc_mode=0 -> 4096 BRAM writes, rom_size=4096, force_bs=1, sc=0, RUN reached 16 cycles after download falls.
REQ-044 Ext ".FAS" style last char "S", sc_mode=0 -> sc=1; same file with sc_mode=1 -> sc=0; unknown ext ".BIN" -> force_bs=0.
REQ-045 Write to ioctl_addr=0x8000 -> mem_we stays 0, rom_size increments; BRAM address 0x0000 is unchanged.
REQ-046 RUN with cpu_req on 3 consecutive cycles at 0x0000/0x0001/0x7FFF -> 3 acks on the next 3 cycles, each carrying the data of its own address.
REQ-047 Reset asserted mid-download at byte 100 with download held high -> rom_size restarts at 0, and a full reload completes with correct contents.
